// File: rtl/ddr_line_arbiter.sv
// Two-master Wishbone arbiter merging DCache (m0) and ICache (m1) line ports onto the DDR slave.
// Grants are held for the whole cyc; a watchdog aborts a stalled strobe and forces a GAP cycle.
module ddr_line_arbiter #(
  parameter int TIMEOUT    = 256,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m0_addr,
  input  logic [511:0] m0_dout,
  input  logic [63:0]  m0_dm,
  input  logic         m0_we,
  input  logic         m0_cyc,
  input  logic         m0_stb,
  output logic         m0_ack,
  output logic         m0_err,
  output logic [511:0] m0_din,
  input  logic [31:0]  m1_addr,
  input  logic [511:0] m1_dout,
  input  logic [63:0]  m1_dm,
  input  logic         m1_we,
  input  logic         m1_cyc,
  input  logic         m1_stb,
  output logic         m1_ack,
  output logic         m1_err,
  output logic [511:0] m1_din,
  output logic [31:0]  s_addr,
  output logic [511:0] s_dout,
  output logic [63:0]  s_dm,
  output logic         s_we,
  output logic         s_cyc,
  output logic         s_stb,
  input  logic         s_ack,
  input  logic [511:0] s_din,
  output logic         busy,
  output logic [1:0]   dbgState
);

  // Handshake: a beat completes in any cycle with s_stb & s_ack; the owner keeps the bus while its cyc is high.
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, GAP = 2'd3} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic          lastGnt;
  logic [CW-1:0] wdCnt;
  logic          err0q, err1q;
  logic          block0, block1;
  logic          req0, req1;
  logic          wdHit;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^{m0_addr[5:0], m1_addr[5:0]};

  always_comb begin
    s_addr = 32'h0;
    s_dout = '0;
    s_dm   = 64'h0;
    s_we   = 1'b0;
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    m0_din = s_din;
    m1_din = s_din;
    case (state)
      GNT0: begin
        s_addr = {m0_addr[31:6], 6'h0};
        s_dout = m0_dout;
        s_dm   = m0_dm;
        s_we   = m0_we;
        s_cyc  = m0_cyc;
        s_stb  = m0_cyc & m0_stb;
        m0_ack = s_ack;
      end
      GNT1: begin
        s_addr = {m1_addr[31:6], 6'h0};
        s_dout = m1_dout;
        s_dm   = m1_dm;
        s_we   = m1_we;
        s_cyc  = m1_cyc;
        s_stb  = m1_cyc & m1_stb;
        m1_ack = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_err   = err0q;
  assign m1_err   = err1q;
  assign busy     = (state == GNT0) | (state == GNT1);
  assign dbgState = state;

  // A master aborted by the watchdog is blocked until its cyc has been seen low once.
  assign req0  = m0_cyc & ~block0;
  assign req1  = m1_cyc & ~block1;
  assign wdHit = (TIMEOUT != 0) && s_stb && !s_ack && (wdCnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lastGnt <= 1'b1;
      wdCnt   <= '0;
      err0q   <= 1'b0;
      err1q   <= 1'b0;
      block0  <= 1'b0;
      block1  <= 1'b0;
    end else begin
      err0q  <= 1'b0;
      err1q  <= 1'b0;
      block0 <= block0 & m0_cyc;
      block1 <= block1 & m1_cyc;
      if (!s_stb || s_ack || wdHit) wdCnt <= '0;
      else                          wdCnt <= wdCnt + 1'b1;
      case (state)
        IDLE: begin
          if (req0 && (!req1 || FIXED_PRIO || lastGnt)) begin
            state   <= GNT0;
            lastGnt <= 1'b0;
          end else if (req1) begin
            state   <= GNT1;
            lastGnt <= 1'b1;
          end
        end
        GNT0: begin
          if (wdHit) begin
            state  <= GAP;
            err0q  <= 1'b1;
            block0 <= 1'b1;
          end else if (!m0_cyc) begin
            state <= GAP;
          end
        end
        GNT1: begin
          if (wdHit) begin
            state  <= GAP;
            err1q  <= 1'b1;
            block1 <= 1'b1;
          end else if (!m1_cyc) begin
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_arbiter.sv
// Bench for ddr_line_arbiter: a vector table, directed corner sequences and a random run
// against a transaction-level ownership model.
module tb_ddr_line_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  m0_addr = '0, m1_addr = '0;
  logic [511:0] m0_dout = '0, m1_dout = '0;
  logic [63:0]  m0_dm = '0, m1_dm = '0;
  logic         m0_we = 1'b0, m1_we = 1'b0;
  logic         m0_cyc = 1'b0, m1_cyc = 1'b0;
  logic         m0_stb = 1'b0, m1_stb = 1'b0;
  logic         m0_ack, m1_ack, m0_err, m1_err;
  logic [511:0] m0_din, m1_din;
  logic [31:0]  s_addr;
  logic [511:0] s_dout;
  logic [63:0]  s_dm;
  logic         s_we, s_cyc, s_stb;
  logic         s_ack = 1'b0;
  logic [511:0] s_din = '0;
  logic         busy;
  logic [1:0]   dbgState;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  ddr_line_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_dm(m0_dm), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_err(m0_err), .m0_din(m0_din),
    .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_dm(m1_dm), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_err(m1_err), .m1_din(m1_din),
    .s_addr(s_addr), .s_dout(s_dout), .s_dm(s_dm), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_ack(s_ack), .s_din(s_din), .busy(busy), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drop_all();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
  endtask

  task automatic idle_bus(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drop_all();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit c0, s0, c1, s1, ack;
    bit eCyc, eStb, eA0, eA1, eBusy;
    int eOwn;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input bit c0, s0, c1, s1, ack, eCyc, eStb, eA0, eA1, eBusy, input int eOwn);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
    v.eCyc = eCyc; v.eStb = eStb; v.eA0 = eA0; v.eA1 = eA1; v.eBusy = eBusy; v.eOwn = eOwn;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  int own;
  bit inGap;
  int lastW;
  int stall;
  bit errP[2];
  bit mustDrop[2];

  task automatic model_reset();
    own = -1; inGap = 0; lastW = 1; stall = 0;
    errP[0] = 0; errP[1] = 0; mustDrop[0] = 0; mustDrop[1] = 0;
  endtask

  task automatic model_check_and_step();
    bit cyc[2], stb[2], we[2];
    logic [31:0] addr[2];
    logic [511:0] dout[2];
    logic [63:0] dm[2];
    bit eCyc, eStb, eWe, to;
    bit nextDrop[2];
    logic [31:0] eAddr;
    logic [511:0] eDout;
    logic [63:0] eDm;
    logic [7:0] act, exp;
    cyc[0] = m0_cyc; stb[0] = m0_stb; we[0] = m0_we; addr[0] = m0_addr; dout[0] = m0_dout; dm[0] = m0_dm;
    cyc[1] = m1_cyc; stb[1] = m1_stb; we[1] = m1_we; addr[1] = m1_addr; dout[1] = m1_dout; dm[1] = m1_dm;
    eCyc = 0; eStb = 0; eWe = 0; eAddr = 0; eDout = 0; eDm = 0;
    if (own >= 0) begin
      eCyc = cyc[own]; eStb = cyc[own] & stb[own]; eWe = we[own];
      eAddr = addr[own] & 32'hFFFF_FFC0; eDout = dout[own]; eDm = dm[own];
    end
    exp_q.push_back({eCyc, eStb, eWe, (own == 0) & s_ack, (own == 1) & s_ack, errP[0], errP[1], own >= 0});
    act = {s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err, busy};
    exp = exp_q.pop_front();
    chk("rnd_ctrl", 512'(act), 512'(exp));
    chk("rnd_addr", 512'(s_addr), 512'(eAddr));
    chk("rnd_dout", s_dout, eDout);
    chk("rnd_dm", 512'(s_dm), 512'(eDm));
    chk("rnd_din0", m0_din, s_din);
    chk("rnd_din1", m1_din, s_din);
    // advance ownership for the next cycle
    errP[0] = 0; errP[1] = 0;
    to = 0;
    if (eStb && !s_ack) begin
      stall++;
      if (stall == 16) begin to = 1; stall = 0; end
    end else stall = 0;
    nextDrop[0] = mustDrop[0] && cyc[0];
    nextDrop[1] = mustDrop[1] && cyc[1];
    if (own >= 0) begin
      if (to) begin
        errP[own] = 1; nextDrop[own] = 1; own = -1; inGap = 1;
      end else if (!cyc[own]) begin
        own = -1; inGap = 1;
      end
    end else if (inGap) begin
      inGap = 0;
    end else begin
      bit r0, r1;
      r0 = cyc[0] && !mustDrop[0];
      r1 = cyc[1] && !mustDrop[1];
      if (r0 && r1) own = 1 - lastW;
      else if (r0) own = 0;
      else if (r1) own = 1;
      if (own >= 0) lastW = own;
    end
    mustDrop[0] = nextDrop[0];
    mustDrop[1] = nextDrop[1];
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] expAddr;
    logic [511:0] pat;
    int stbCount;
    bit errSeen;

    // reset state with requests already present
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_s_cyc", 512'(s_cyc), 512'(0));
    chk("rst_s_stb", 512'(s_stb), 512'(0));
    chk("rst_s_addr", 512'(s_addr), 512'(0));
    chk("rst_acks", 512'({m0_ack, m1_ack, m0_err, m1_err, busy, s_we}), 512'(0));
    drop_all();
    next_cycle();
    rst = 0;

    // table: stray acks, ties with round-robin, locked grant, ack on cyc fall
    m0_addr = 32'h0001_2357; m1_addr = 32'h0ABC_DEFF;
    m0_we = 0; m1_we = 1;
    m0_dout = {16{32'h1111_0000}}; m1_dout = {16{32'h2222_FFFF}};
    m0_dm = 64'h0F0F_0F0F_0F0F_0F0F; m1_dm = 64'hF0F0_F0F0_F0F0_F0F0;
    //       c0 s0 c1 s1 ak  cyc stb a0 a1 busy own
    add_vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  1, 1, 0, 0, 1, 1);
    add_vec(1, 1, 1, 1, 1,  1, 1, 1, 0, 1, 1);
    add_vec(0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 1);
    add_vec(1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  1, 1, 0, 0, 1, 2);
    add_vec(1, 1, 1, 1, 1,  1, 1, 0, 1, 1, 2);
    add_vec(1, 1, 0, 0, 1,  0, 0, 0, 1, 1, 2);
    add_vec(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 0,  1, 1, 0, 0, 1, 1);
    add_vec(1, 0, 1, 1, 0,  1, 0, 0, 0, 1, 1);
    add_vec(0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 1);
    add_vec(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 0,  1, 1, 0, 0, 1, 2);
    add_vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2);
    add_vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      next_cycle();
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; s_ack = tbl[i].ack;
      s_din = rand512();
      settle();
      chk($sformatf("tbl%0d_cyc", i), 512'(s_cyc), 512'(tbl[i].eCyc));
      chk($sformatf("tbl%0d_stb", i), 512'(s_stb), 512'(tbl[i].eStb));
      chk($sformatf("tbl%0d_ack0", i), 512'(m0_ack), 512'(tbl[i].eA0));
      chk($sformatf("tbl%0d_ack1", i), 512'(m1_ack), 512'(tbl[i].eA1));
      chk($sformatf("tbl%0d_busy", i), 512'(busy), 512'(tbl[i].eBusy));
      expAddr = (tbl[i].eOwn == 1) ? 32'h0001_2340 : (tbl[i].eOwn == 2) ? 32'h0ABC_DEC0 : 32'h0;
      chk($sformatf("tbl%0d_addr", i), 512'(s_addr), 512'(expAddr));
      chk($sformatf("tbl%0d_we", i), 512'(s_we), 512'(tbl[i].eOwn == 2));
      pat = (tbl[i].eOwn == 1) ? {16{32'h1111_0000}} : (tbl[i].eOwn == 2) ? {16{32'h2222_FFFF}} : '0;
      chk($sformatf("tbl%0d_dout", i), s_dout, pat);
    end
    idle_bus(3);

    // single read with 5-cycle DDR latency
    next_cycle();
    m0_addr = 32'h0001_2340; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    settle();
    chk("t1_latency", 512'(s_cyc), 512'(0));
    next_cycle();
    settle();
    chk("t1_s_cyc", 512'(s_cyc), 512'(1));
    chk("t1_s_addr", 512'(s_addr), 512'(32'h0001_2340));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      chk("t1_wait_ack", 512'({m0_ack, m1_ack}), 512'(0));
    end
    next_cycle();
    s_ack = 1; s_din = {64{8'hA5}};
    settle();
    chk("t1_m0_ack", 512'(m0_ack), 512'(1));
    chk("t1_m0_din", m0_din, {64{8'hA5}});
    chk("t1_m1_ack", 512'(m1_ack), 512'(0));
    next_cycle();
    drop_all();
    settle();
    chk("t1_ack_once", 512'(m0_ack), 512'(0));
    idle_bus(3);

    // locked read-then-write while m1 waits
    next_cycle();
    m0_addr = 32'h0002_0000; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    next_cycle();
    m1_cyc = 1; m1_stb = 1;
    settle();
    chk("t3_owner_m0", 512'(s_addr), 512'(32'h0002_0000));
    next_cycle();
    s_ack = 1; s_din = rand512();
    settle();
    chk("t3_rd_ack", 512'({m0_ack, m1_ack}), 512'(2'b10));
    next_cycle();
    s_ack = 0; m0_we = 1; m0_dm = 64'hFFFF_0000_0000_0000; m0_dout = {16{32'hCAFE_BEEF}};
    settle();
    chk("t3_wr_we", 512'(s_we), 512'(1));
    chk("t3_wr_dm", 512'(s_dm), 512'(64'hFFFF_0000_0000_0000));
    chk("t3_wr_dout", s_dout, {16{32'hCAFE_BEEF}});
    chk("t3_wr_owner", 512'(s_addr), 512'(32'h0002_0000));
    next_cycle();
    s_ack = 1;
    settle();
    chk("t3_wr_ack", 512'({m0_ack, m1_ack}), 512'(2'b10));
    next_cycle();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    settle();
    chk("t3_release", 512'({s_cyc, busy}), 512'(2'b01));
    next_cycle();
    settle();
    chk("t3_gap", 512'({s_cyc, busy}), 512'(2'b00));
    next_cycle();
    settle();
    chk("t3_idle", 512'({s_cyc, busy}), 512'(2'b00));
    next_cycle();
    settle();
    chk("t3_gnt1_cyc", 512'(s_cyc), 512'(1));
    chk("t3_gnt1_addr", 512'(s_addr), 512'({m1_addr[31:6], 6'h0}));
    idle_bus(3);

    // watchdog on a never-acked m1 strobe
    next_cycle();
    m1_addr = 32'h0000_4000; m1_cyc = 1; m1_stb = 1;
    stbCount = 0; errSeen = 0;
    for (int i = 0; i < 40 && !errSeen; i++) begin
      next_cycle();
      settle();
      if (m1_err) errSeen = 1;
      else if (s_stb) stbCount++;
    end
    chk("t4_err_seen", 512'(errSeen), 512'(1));
    chk("t4_stb_cycles", 512'(stbCount), 512'(16));
    chk("t4_abort_bus", 512'({s_cyc, s_stb, m0_err, busy}), 512'(0));
    next_cycle();
    settle();
    chk("t4_err_pulse", 512'(m1_err), 512'(0));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      settle();
      chk("t4_no_regrant", 512'({s_cyc, busy}), 512'(0));
    end
    next_cycle();
    m1_cyc = 0; m1_stb = 0;
    next_cycle();
    m1_cyc = 1; m1_stb = 1;
    settle();
    chk("t4_regrant_wait", 512'(s_cyc), 512'(0));
    next_cycle();
    settle();
    chk("t4_regrant", 512'(s_cyc), 512'(1));
    idle_bus(3);

    // async reset mid-transaction, then the first tie goes to m0
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0003_0000;
    next_cycle();
    settle();
    chk("t5_pre_stb", 512'(s_stb), 512'(1));
    s_ack = 1; rst = 1;
    #1;
    chk("t5_rst_bus", 512'({s_cyc, s_stb, m0_ack, busy}), 512'(0));
    drop_all();
    next_cycle();
    next_cycle();
    rst = 0;
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    next_cycle();
    settle();
    chk("t5_tie_m0", 512'({s_cyc, s_addr}), 512'({1'b1, 32'h0003_0000}));
    idle_bus(3);

    // randomized run against the ownership model
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit quiet;
      next_cycle();
      quiet = ((n / 50) % 3) == 2;
      if (m0_cyc) m0_cyc = ($urandom_range(quiet ? 39 : 7) != 0);
      else        m0_cyc = ($urandom_range(3) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(quiet ? 39 : 7) != 0);
      else        m1_cyc = ($urandom_range(3) == 0);
      m0_stb = m0_cyc & (quiet || $urandom_range(3) != 0);
      m1_stb = m1_cyc & (quiet || $urandom_range(3) != 0);
      s_ack = quiet ? 1'b0 : ($urandom_range(2) == 0);
      m0_addr = $urandom; m1_addr = $urandom;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_dm = {$urandom, $urandom}; m1_dm = {$urandom, $urandom};
      m0_dout = rand512(); m1_dout = rand512(); s_din = rand512();
      settle();
      model_check_and_step();
    end
    idle_bus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
